id_ex_forward_stage: RTL and testbench

//   ID/EX pipeline register for the 5-stage datapath. Captures decoded operands, control word and
//   the operand-forwarding selects produced in decode, and presents them to the EX-stage operand

---
 rtl/id_ex_forward_stage_pkg.sv | 32 +++
 rtl/id_ex_forward_stage_fwd_promote.sv | 20 ++
 rtl/id_ex_forward_stage.sv | 164 ++++++++++++++++
 tb/tb_id_ex_forward_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_forward_stage_pkg.sv
// Shared pipeline definitions: forward-select encodings, ID/EX stage states,
// the per-cycle register-bank action, and default datapath widths.
package pipe_pkg;

  // Operand-forwarding select encodings driven to the EX operand muxes.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_RSVD  = 2'b11;

  // Default datapath widths.
  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 4;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 16;

  // ID/EX stage control states.
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    BUBBLE = 2'b01,
    HOLD   = 2'b10
  } state_t;

  // What the ID/EX register bank does on the coming clock edge.
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'b00,  // capture id_* into ex_*
    ACT_HOLD   = 2'b01,  // keep every ex_* register
    ACT_BUBBLE = 2'b10,  // clear ex_valid, keep ex_* data
    ACT_KILL   = 2'b11   // flush: clear ex_valid, keep ex_* data
  } act_t;

endpackage

// File: rtl/id_ex_forward_stage_fwd_promote.sv
// Combinational forward-select promotion: when enabled, an EX/MEM select
// becomes MEM/WB because the producer has advanced one stage. RF, MEM/WB and
// the reserved encoding always pass through unchanged.
module fwd_promote
  import pipe_pkg::*;
(
  input  logic       en,
  input  logic [1:0] sel_in,
  output logic [1:0] sel_out
);

  // Promote only the EX/MEM encoding, and only when enabled.
  always_comb begin
    sel_out = sel_in;
    if (en && (sel_in == FWD_EXMEM)) begin
      sel_out = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with operand-forwarding selects, load-use bubble
// insertion, EX multi-cycle hold and a saturating stall counter.
//
// Handshake: stall_up is the only backpressure signal. When stall_up=1 the
// upstream stages (PC, IF/ID) must hold their contents so the same id_*
// values are presented again on the next cycle; this stage never drops an
// instruction that it stalled. flush squashes whatever this stage would have
// captured, and upstream is squashed by its own owner.
module id_ex_forward_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_op1,
  input  logic [REG_W-1:0]  id_op2,
  input  logic [DATA_W-1:0] id_a_data,
  input  logic [DATA_W-1:0] id_b_data,
  input  logic [1:0]        id_fwd_a,
  input  logic [1:0]        id_fwd_b,
  input  logic              id_hazard,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_busy,
  input  logic              flush,
  output logic              stall_up,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_op1,
  output logic [REG_W-1:0]  ex_op2,
  output logic [DATA_W-1:0] ex_a_data,
  output logic [DATA_W-1:0] ex_b_data,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  // Stage state, named so checkers can bind to it directly.
  state_t     state;
  state_t     state_next;
  act_t       act;
  logic       promote;
  logic       stall_c;
  logic       lu;
  logic [1:0] fwd_a_p;
  logic [1:0] fwd_b_p;

  // Load-use: the instruction in EX is a load whose result the decode slot
  // wants through the EX/MEM forward path, which cannot have it yet.
  assign lu = id_valid & id_hazard & ex_valid & ex_is_load &
              ((id_fwd_a == FWD_EXMEM) | (id_fwd_b == FWD_EXMEM));

  // Select promotion for the reload that follows a bubble.
  fwd_promote u_promote_a (
    .en      (promote),
    .sel_in  (id_fwd_a),
    .sel_out (fwd_a_p)
  );

  fwd_promote u_promote_b (
    .en      (promote),
    .sel_in  (id_fwd_b),
    .sel_out (fwd_b_p)
  );

  // Next-state, register-bank action and upstream stall; flush > ex_busy > lu.
  // Leaving HOLD re-evaluates lu: if the held instruction is a load feeding
  // the decode slot, a bubble is still required before the dependent enters.
  always_comb begin
    state_next = state;
    act        = ACT_LOAD;
    promote    = 1'b0;
    stall_c    = 1'b0;
    if (flush) begin
      act        = ACT_KILL;
      state_next = RUN;
    end else begin
      case (state)
        RUN, BUBBLE, HOLD: begin
          if (ex_busy) begin
            act        = ACT_HOLD;
            stall_c    = 1'b1;
            state_next = HOLD;
          end else if (lu) begin
            act        = ACT_BUBBLE;
            stall_c    = 1'b1;
            state_next = BUBBLE;
          end else begin
            act        = ACT_LOAD;
            promote    = (state == BUBBLE);
            state_next = RUN;
          end
        end
        default: begin
          act        = ACT_KILL;
          state_next = RUN;
        end
      endcase
    end
  end

  // Reset forces stall_up low immediately, whatever the state register held.
  assign stall_up = rst_n & stall_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // ID/EX register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_a_data  <= '0;
      ex_b_data  <= '0;
      ex_fwd_a   <= FWD_RF;
      ex_fwd_b   <= FWD_RF;
      ex_is_load <= 1'b0;
      ex_ctrl    <= '0;
    end else begin
      case (act)
        ACT_LOAD: begin
          ex_valid   <= id_valid;
          ex_op1     <= id_op1;
          ex_op2     <= id_op2;
          ex_a_data  <= id_a_data;
          ex_b_data  <= id_b_data;
          ex_fwd_a   <= fwd_a_p;
          ex_fwd_b   <= fwd_b_p;
          ex_is_load <= id_is_load;
          ex_ctrl    <= id_ctrl;
        end
        ACT_BUBBLE, ACT_KILL: begin
          ex_valid <= 1'b0;
        end
        default: begin
          ex_valid <= ex_valid;
        end
      endcase
    end
  end

  // Saturating count of cycles in which upstream was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall_up && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Directed bench for id_ex_forward_stage: reset, normal flow, load-use bubble
// with select promotion, multi-cycle hold, flushes, reset in HOLD and
// stall-counter saturation on a narrow-counter instance.
module tb_id_ex_forward_stage;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        id_valid, id_hazard, id_is_load, ex_busy, flush;
  logic [3:0]  id_op1, id_op2;
  logic [15:0] id_a_data, id_b_data;
  logic [1:0]  id_fwd_a, id_fwd_b;
  logic [7:0]  id_ctrl;

  logic        stall_up, ex_valid, ex_is_load;
  logic [3:0]  ex_op1, ex_op2;
  logic [15:0] ex_a_data, ex_b_data;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic [7:0]  ex_ctrl;
  logic [15:0] stall_count;

  logic        s_stall_up, s_ex_valid, s_ex_is_load;
  logic [3:0]  s_ex_op1, s_ex_op2;
  logic [15:0] s_ex_a_data, s_ex_b_data;
  logic [1:0]  s_ex_fwd_a, s_ex_fwd_b;
  logic [7:0]  s_ex_ctrl;
  logic [3:0]  s_stall_count;

  int vectors = 0;
  int errors  = 0;

  id_ex_forward_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op1(id_op1), .id_op2(id_op2),
    .id_a_data(id_a_data), .id_b_data(id_b_data), .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b),
    .id_hazard(id_hazard), .id_is_load(id_is_load), .id_ctrl(id_ctrl), .ex_busy(ex_busy),
    .flush(flush), .stall_up(stall_up), .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_a_data(ex_a_data), .ex_b_data(ex_b_data), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  id_ex_forward_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op1(id_op1), .id_op2(id_op2),
    .id_a_data(id_a_data), .id_b_data(id_b_data), .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b),
    .id_hazard(id_hazard), .id_is_load(id_is_load), .id_ctrl(id_ctrl), .ex_busy(ex_busy),
    .flush(flush), .stall_up(s_stall_up), .ex_valid(s_ex_valid), .ex_op1(s_ex_op1),
    .ex_op2(s_ex_op2), .ex_a_data(s_ex_a_data), .ex_b_data(s_ex_b_data),
    .ex_fwd_a(s_ex_fwd_a), .ex_fwd_b(s_ex_fwd_b), .ex_is_load(s_ex_is_load),
    .ex_ctrl(s_ex_ctrl), .stall_count(s_stall_count)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [3:0] o1, input logic [3:0] o2,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] fa, input logic [1:0] fb,
                          input logic haz, input logic ld, input logic [7:0] c);
    id_valid = v;  id_op1 = o1; id_op2 = o2; id_a_data = a; id_b_data = b;
    id_fwd_a = fa; id_fwd_b = fb; id_hazard = haz; id_is_load = ld; id_ctrl = c;
  endtask

  task automatic idle();
    drive_id(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
    ex_busy = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset ex_valid got %b want 0", ex_valid); end
    vectors++; if (ex_a_data !== 16'h0) begin errors++; $display("FAIL reset ex_a_data got %h want 0000", ex_a_data); end
    vectors++; if (ex_fwd_b !== 2'b00) begin errors++; $display("FAIL reset ex_fwd_b got %b want 00", ex_fwd_b); end
    vectors++; if (stall_up !== 1'b0) begin errors++; $display("FAIL reset stall_up got %b want 0", stall_up); end
    vectors++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset stall_count got %0d want 0", stall_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    drive_id(1'b1, 4'd3, 4'd5, 16'h1234, 16'habcd, 2'b00, 2'b10, 1'b0, 1'b0, 8'h5a);
    #1;
    vectors++; if (stall_up !== 1'b0) begin errors++; $display("FAIL normal stall_up got %b want 0", stall_up); end
    tick();
    vectors++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL normal ex_valid got %b want 1", ex_valid); end
    vectors++; if (ex_a_data !== 16'h1234) begin errors++; $display("FAIL normal ex_a_data got %h want 1234", ex_a_data); end
    vectors++; if (ex_b_data !== 16'habcd) begin errors++; $display("FAIL normal ex_b_data got %h want abcd", ex_b_data); end
    vectors++; if (ex_op1 !== 4'd3 || ex_op2 !== 4'd5) begin errors++; $display("FAIL normal ex_op got %0d/%0d want 3/5", ex_op1, ex_op2); end
    vectors++; if (ex_fwd_a !== 2'b00 || ex_fwd_b !== 2'b10) begin errors++; $display("FAIL normal fwd got %b/%b want 00/10", ex_fwd_a, ex_fwd_b); end
    vectors++; if (ex_ctrl !== 8'h5a) begin errors++; $display("FAIL normal ex_ctrl got %h want 5a", ex_ctrl); end
    // Invalid slot with reserved select: passes through, ex_valid follows id_valid.
    drive_id(1'b0, 4'd9, 4'd1, 16'h0f0f, 16'hf0f0, 2'b11, 2'b01, 1'b0, 1'b1, 8'hc3);
    tick();
    vectors++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL normal2 ex_valid got %b want 0", ex_valid); end
    vectors++; if (ex_fwd_a !== 2'b11 || ex_fwd_b !== 2'b01) begin errors++; $display("FAIL normal2 fwd got %b/%b want 11/01", ex_fwd_a, ex_fwd_b); end
    vectors++; if (ex_is_load !== 1'b1 || ex_op1 !== 4'd9) begin errors++; $display("FAIL normal2 load/op1 got %b/%0d want 1/9", ex_is_load, ex_op1); end
    vectors++; if (stall_count !== 16'd0) begin errors++; $display("FAIL normal stall_count got %0d want 0", stall_count); end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    // Load into EX.
    drive_id(1'b1, 4'd7, 4'd0, 16'h1111, 16'h0bbb, 2'b00, 2'b00, 1'b0, 1'b1, 8'h11);
    tick();
    vectors++; if (ex_is_load !== 1'b1 || ex_valid !== 1'b1) begin errors++; $display("FAIL lu_setup load/valid got %b/%b want 1/1", ex_is_load, ex_valid); end
    // Dependent instruction reading the load result through EX/MEM.
    drive_id(1'b1, 4'd8, 4'd7, 16'h3333, 16'h2222, 2'b11, 2'b01, 1'b1, 1'b0, 8'h22);
    #1;
    vectors++; if (stall_up !== 1'b1) begin errors++; $display("FAIL lu stall_up got %b want 1", stall_up); end
    tick();
    vectors++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble ex_valid got %b want 0", ex_valid); end
    vectors++; if (ex_b_data !== 16'h0bbb) begin errors++; $display("FAIL lu_bubble ex_b_data got %h want 0bbb", ex_b_data); end
    vectors++; if (stall_up !== 1'b0) begin errors++; $display("FAIL lu_bubble stall_up got %b want 0", stall_up); end
    vectors++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu stall_count got %0d want 1", stall_count); end
    tick();
    vectors++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL lu_reload ex_valid got %b want 1", ex_valid); end
    vectors++; if (ex_fwd_b !== 2'b10) begin errors++; $display("FAIL lu_reload ex_fwd_b got %b want 10", ex_fwd_b); end
    vectors++; if (ex_fwd_a !== 2'b11) begin errors++; $display("FAIL lu_reload ex_fwd_a got %b want 11", ex_fwd_a); end
    vectors++; if (ex_b_data !== 16'h2222 || ex_op2 !== 4'd7) begin errors++; $display("FAIL lu_reload data got %h/%0d want 2222/7", ex_b_data, ex_op2); end
    vectors++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_reload stall_count got %0d want 1", stall_count); end
    idle();
    tick();
  endtask

  task automatic test_hold();
    pulse_reset();
    drive_id(1'b1, 4'd2, 4'd0, 16'h5555, 16'h0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h33);
    tick();
    drive_id(1'b1, 4'd4, 4'd0, 16'h6666, 16'h0, 2'b00, 2'b00, 1'b0, 1'b1, 8'h44);
    ex_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (stall_up !== 1'b1) begin errors++; $display("FAIL hold[%0d] stall_up got %b want 1", i, stall_up); end
      tick();
      vectors++; if (ex_a_data !== 16'h5555 || ex_op1 !== 4'd2) begin errors++; $display("FAIL hold[%0d] frozen got %h/%0d want 5555/2", i, ex_a_data, ex_op1); end
    end
    ex_busy = 1'b0;
    #1;
    vectors++; if (stall_up !== 1'b0) begin errors++; $display("FAIL hold_exit stall_up got %b want 0", stall_up); end
    vectors++; if (stall_count !== 16'd3) begin errors++; $display("FAIL hold stall_count got %0d want 3", stall_count); end
    tick();
    vectors++; if (ex_a_data !== 16'h6666 || ex_op1 !== 4'd4 || ex_valid !== 1'b1) begin errors++; $display("FAIL hold_exit load got %h/%0d/%b want 6666/4/1", ex_a_data, ex_op1, ex_valid); end
    vectors++; if (stall_count !== 16'd3) begin errors++; $display("FAIL hold_exit stall_count got %0d want 3", stall_count); end
    idle();
    tick();
  endtask

  task automatic test_flush();
    // Flush while in BUBBLE.
    drive_id(1'b1, 4'd6, 4'd0, 16'h0a0a, 16'h0, 2'b00, 2'b00, 1'b0, 1'b1, 8'h55);
    tick();
    drive_id(1'b1, 4'd1, 4'd6, 16'h0, 16'h7777, 2'b00, 2'b01, 1'b1, 1'b0, 8'h66);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_bubble ex_valid got %b want 0", ex_valid); end
    vectors++; if (ex_fwd_b !== 2'b00) begin errors++; $display("FAIL flush_bubble ex_fwd_b got %b want 00", ex_fwd_b); end
    // Back in RUN: an EX/MEM select with no hazard loads unpromoted.
    drive_id(1'b1, 4'd1, 4'd6, 16'h0, 16'h8888, 2'b00, 2'b01, 1'b0, 1'b0, 8'h67);
    tick();
    vectors++; if (ex_valid !== 1'b1 || ex_fwd_b !== 2'b01) begin errors++; $display("FAIL flush_bubble_run valid/fwd_b got %b/%b want 1/01", ex_valid, ex_fwd_b); end
    // Flush while in HOLD.
    drive_id(1'b1, 4'd2, 4'd3, 16'h9999, 16'h0, 2'b00, 2'b01, 1'b0, 1'b0, 8'h77);
    ex_busy = 1'b1;
    tick();
    flush = 1'b1;
    #1;
    vectors++; if (stall_up !== 1'b0) begin errors++; $display("FAIL flush_hold stall_up got %b want 0", stall_up); end
    tick();
    flush = 1'b0;
    ex_busy = 1'b0;
    vectors++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_hold ex_valid got %b want 0", ex_valid); end
    tick();
    vectors++; if (ex_valid !== 1'b1 || ex_fwd_b !== 2'b01 || ex_a_data !== 16'h9999) begin errors++; $display("FAIL flush_hold_run got %b/%b/%h want 1/01/9999", ex_valid, ex_fwd_b, ex_a_data); end
    idle();
    tick();
  endtask

  task automatic test_reset_in_hold();
    drive_id(1'b1, 4'd5, 4'd0, 16'h4242, 16'h0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h88);
    tick();
    ex_busy = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    vectors++; if (stall_up !== 1'b0) begin errors++; $display("FAIL rst_hold stall_up got %b want 0", stall_up); end
    vectors++; if (ex_valid !== 1'b0 || ex_a_data !== 16'h0) begin errors++; $display("FAIL rst_hold ex got %b/%h want 0/0000", ex_valid, ex_a_data); end
    vectors++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rst_hold stall_count got %0d want 0", stall_count); end
    idle();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    pulse_reset();
    ex_busy = 1'b1;
    repeat (20) tick();
    ex_busy = 1'b0;
    #1;
    vectors++; if (s_stall_count !== 4'hf) begin errors++; $display("FAIL sat stall_count got %h want f", s_stall_count); end
    vectors++; if (stall_count !== 16'd20) begin errors++; $display("FAIL sat wide stall_count got %0d want 20", stall_count); end
    tick();
    vectors++; if (s_stall_count !== 4'hf) begin errors++; $display("FAIL sat_after stall_count got %h want f", s_stall_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_normal();
    test_load_use();
    test_hold();
    test_flush();
    test_reset_in_hold();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
